// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the SPI RAM command sequencer.
// Opcode 8'h05 (status) is only decoded when SPI_RAM_CTRL_STATUS_EN is defined.
package spi_ram_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 8;

    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_STATUS = 8'h05;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_WR_DATA,
        ST_RD_DATA,
        ST_IGNORE,
        ST_RD_STATUS
    } state_t;

endpackage

// File: rtl/spi_ram_rd_pipe.sv
// Read-valid shift register: a trigger becomes o_Load two cycles later (RAM data
// present) and o_Valid three cycles later (TX byte loaded). Flush kills everything in flight.
module spi_ram_rd_pipe #(
    parameter int DEPTH = 3
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Flush,
    input  logic i_Trig,
    output logic o_Load,
    output logic o_Valid
);

    logic stage_reg [0:DEPTH-1];

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst)        stage_reg[0] <= 1'b0;
        else if (i_Flush) stage_reg[0] <= 1'b0;
        else              stage_reg[0] <= i_Trig;
    end

    genvar gi;
    generate
        for (gi = 1; gi < DEPTH; gi++) begin : g_stage
            always_ff @(posedge i_Clk or posedge i_Rst) begin
                if (i_Rst)        stage_reg[gi] <= 1'b0;
                else if (i_Flush) stage_reg[gi] <= 1'b0;
                else              stage_reg[gi] <= stage_reg[gi-1];
            end
        end
    endgenerate

    assign o_Load  = stage_reg[DEPTH-2];
    assign o_Valid = stage_reg[DEPTH-1];

endmodule

// File: rtl/spi_ram_ctrl.sv
// Byte-stream command sequencer driving an external dual-port SPI RAM.
// Define SPI_RAM_CTRL_STATUS_EN to add the 8'h05 write-counter status command.
module spi_ram_ctrl #(
    parameter int         ADDR_W    = spi_ram_pkg::DEF_ADDR_W,
    parameter int         DATA_W    = spi_ram_pkg::DEF_DATA_W,
    parameter logic [7:0] CMD_WRITE = spi_ram_pkg::CMD_WRITE,
    parameter logic [7:0] CMD_READ  = spi_ram_pkg::CMD_READ
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_CS_n,
    input  logic              i_RX_DV,
    input  logic [DATA_W-1:0] i_RX_Byte,
    output logic              o_TX_DV,
    output logic [DATA_W-1:0] o_TX_Byte,
    output logic [DATA_W-1:0] o_RAM_wData,
    output logic              o_RAM_wEnable,
    output logic [ADDR_W-1:0] o_RAM_wAddress,
    output logic [ADDR_W-1:0] o_RAM_rAddress,
    input  logic [DATA_W-1:0] i_RAM_rData,
    output logic              o_Busy
);
    import spi_ram_pkg::*;

    state_t            state_reg, state_next;
    logic [7:0]        opcode_reg;
    logic [ADDR_W-1:0] addr_reg, waddr_reg, raddr_reg, addr_inc;
    logic [DATA_W-1:0] wdata_reg, tx_byte_reg, status_byte;
    logic              wen_reg, rx_take, rd_trig, rd_load, rd_valid, stat_trig;

    assign rx_take  = i_RX_DV & ~i_CS_n;
    assign addr_inc = addr_reg + ADDR_W'(1);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // Chip-select high always wins and returns to IDLE, discarding any byte.
    always_comb begin
        state_next = state_reg;
        if (i_CS_n) begin
            state_next = ST_IDLE;
        end else if (i_RX_DV) begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_RX_Byte == CMD_WRITE || i_RX_Byte == CMD_READ)
                        state_next = ST_ADDR_HI;
`ifdef SPI_RAM_CTRL_STATUS_EN
                    else if (i_RX_Byte == CMD_STATUS)
                        state_next = ST_RD_STATUS;
`endif
                    else
                        state_next = ST_IGNORE;
                end
                ST_ADDR_HI: state_next = ST_ADDR_LO;
                ST_ADDR_LO: state_next = (opcode_reg == CMD_WRITE) ? ST_WR_DATA : ST_RD_DATA;
                default: ;
            endcase
        end
    end

    always_comb begin
        o_Busy        = (state_reg != ST_IDLE);
        o_RAM_wEnable = wen_reg & ~i_CS_n;
        rd_trig       = rx_take & (((state_reg == ST_ADDR_LO) && (opcode_reg == CMD_READ)) ||
                                   (state_reg == ST_RD_DATA));
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            opcode_reg <= '0;
            addr_reg   <= '0;
            waddr_reg  <= '0;
            raddr_reg  <= '0;
            wdata_reg  <= '0;
            wen_reg    <= 1'b0;
        end else begin
            wen_reg <= 1'b0;
            if (rx_take) begin
                case (state_reg)
                    ST_IDLE:    opcode_reg <= i_RX_Byte[7:0];
                    ST_ADDR_HI: addr_reg[ADDR_W-1:DATA_W] <= i_RX_Byte[ADDR_W-DATA_W-1:0];
                    ST_ADDR_LO: begin
                        addr_reg[DATA_W-1:0] <= i_RX_Byte;
                        raddr_reg            <= {addr_reg[ADDR_W-1:DATA_W], i_RX_Byte};
                    end
                    ST_WR_DATA: begin
                        wen_reg   <= 1'b1;
                        waddr_reg <= addr_reg;
                        wdata_reg <= i_RX_Byte;
                        addr_reg  <= addr_inc;
                    end
                    ST_RD_DATA: begin
                        addr_reg  <= addr_inc;
                        raddr_reg <= addr_inc;
                    end
                    default: ;
                endcase
            end
        end
    end

    spi_ram_rd_pipe #(.DEPTH(3)) u_rd_pipe (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Flush (i_CS_n),
        .i_Trig  (rd_trig),
        .o_Load  (rd_load),
        .o_Valid (rd_valid)
    );

`ifdef SPI_RAM_CTRL_STATUS_EN
    logic [7:0] wr_count_reg;
    logic       stat_dv_reg;

    assign stat_trig   = rx_take & (((state_reg == ST_IDLE) && (i_RX_Byte == CMD_STATUS)) ||
                                    (state_reg == ST_RD_STATUS));
    assign status_byte = wr_count_reg;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            wr_count_reg <= '0;
            stat_dv_reg  <= 1'b0;
        end else begin
            stat_dv_reg <= stat_trig;
            if (o_RAM_wEnable && wr_count_reg != 8'hFF)
                wr_count_reg <= wr_count_reg + 8'd1;
        end
    end

    assign o_TX_DV = rd_valid | stat_dv_reg;
`else
    assign stat_trig   = 1'b0;
    assign status_byte = '0;
    assign o_TX_DV     = rd_valid;
`endif

    // Only capture read data for a read that survives; the byte holds otherwise.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst)                   tx_byte_reg <= '0;
        else if (rd_load && !i_CS_n) tx_byte_reg <= i_RAM_rData;
        else if (stat_trig)          tx_byte_reg <= status_byte;
    end

    assign o_TX_Byte      = tx_byte_reg;
    assign o_RAM_wData    = wdata_reg;
    assign o_RAM_wAddress = waddr_reg;
    assign o_RAM_rAddress = raddr_reg;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Self-checking bench for spi_ram_ctrl with a behavioural RAM and a frame-level reference model.
module tb_spi_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst, cs_n, rx_dv, preload;
    logic [7:0] rx_byte, tx_byte, ram_wdata, ram_rdata;
    logic       tx_dv, ram_wen, busy;
    logic [9:0] ram_waddr, ram_raddr;
    logic [7:0] ram [0:1023];
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_ram_ctrl dut (
        .i_Clk          (clk),
        .i_Rst          (rst),
        .i_CS_n         (cs_n),
        .i_RX_DV        (rx_dv),
        .i_RX_Byte      (rx_byte),
        .o_TX_DV        (tx_dv),
        .o_TX_Byte      (tx_byte),
        .o_RAM_wData    (ram_wdata),
        .o_RAM_wEnable  (ram_wen),
        .o_RAM_wAddress (ram_waddr),
        .o_RAM_rAddress (ram_raddr),
        .i_RAM_rData    (ram_rdata),
        .o_Busy         (busy)
    );

    function automatic logic [7:0] seed(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    // Registered-read dual-port RAM
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) ram[i] <= seed(i);
        end else if (ram_wen) begin
            ram[ram_waddr] <= ram_wdata;
        end
        ram_rdata <= ram[ram_raddr];
    end

    typedef struct { logic [9:0] a; logic [7:0] d; int c; } wr_t;
    typedef struct { logic [7:0] d; int c; } tx_t;
    wr_t wr_log[$], exp_wr[$];
    tx_t tx_log[$], exp_tx[$];

    always @(negedge clk) begin
        if (ram_wen) wr_log.push_back('{ram_waddr, ram_wdata, cyc});
        if (tx_dv)   tx_log.push_back('{tx_byte, cyc});
    end

    logic [7:0] ref_mem [0:1023];
    int         wcount;
    logic [7:0] frame_buf [0:15];
    int         send_cyc  [0:15];
    int         tests_run = 0;
    int         fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_logs(input string tag);
        int n;
        check({tag, "_nwr"}, 32'(wr_log.size()), 32'(exp_wr.size()));
        n = (wr_log.size() < exp_wr.size()) ? wr_log.size() : exp_wr.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_waddr"}, 32'(wr_log[i].a), 32'(exp_wr[i].a));
            check({tag, "_wdata"}, 32'(wr_log[i].d), 32'(exp_wr[i].d));
            check({tag, "_wcyc"},  wr_log[i].c, exp_wr[i].c);
        end
        check({tag, "_ntx"}, 32'(tx_log.size()), 32'(exp_tx.size()));
        n = (tx_log.size() < exp_tx.size()) ? tx_log.size() : exp_tx.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_txdata"}, 32'(tx_log[i].d), 32'(exp_tx[i].d));
            check({tag, "_txcyc"},  tx_log[i].c, exp_tx[i].c);
        end
        $display("[TB] %s: %0d writes, %0d tx bytes", tag, wr_log.size(), tx_log.size());
        wr_log.delete(); exp_wr.delete(); tx_log.delete(); exp_tx.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, output int sc);
        @(negedge clk);
        rx_dv = 1'b1; rx_byte = b; sc = cyc;
        @(negedge clk);
        rx_dv = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic end_frame();
        @(negedge clk); cs_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_frame(input int n, input bit keep_cs);
        @(negedge clk); cs_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < n; i++) send_byte(frame_buf[i], send_cyc[i]);
        repeat (2) @(negedge clk);
        if (!keep_cs) end_frame();
    endtask

    // Expected RAM writes / TX bytes of a complete frame, from the command rules
    task automatic model_frame(input int n);
        logic [7:0] op;
        int a;
        op = frame_buf[0];
        if ((op == 8'h02 || op == 8'h03) && n >= 3) begin
            a = {frame_buf[1][1:0], frame_buf[2]};
            if (op == 8'h03) exp_tx.push_back('{ref_mem[a], send_cyc[2] + 3});
            for (int i = 3; i < n; i++) begin
                if (op == 8'h02) begin
                    exp_wr.push_back('{10'(a), frame_buf[i], send_cyc[i] + 1});
                    ref_mem[a] = frame_buf[i];
                    if (wcount < 255) wcount++;
                    a = (a + 1) % 1024;
                end else begin
                    a = (a + 1) % 1024;
                    exp_tx.push_back('{ref_mem[a], send_cyc[i] + 3});
                end
            end
        end
`ifdef SPI_RAM_CTRL_STATUS_EN
        else if (op == 8'h05) begin
            for (int i = 0; i < n; i++) exp_tx.push_back('{8'(wcount), send_cyc[i] + 1});
        end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int sc;
        logic [9:0] ra;
        logic [7:0] op;
        int n;

        rst = 1'b1; cs_n = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; preload = 1'b1; wcount = 0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = seed(i);
        repeat (3) @(negedge clk);
        check("rst_busy",  32'(busy), 0);
        check("rst_wen",   32'(ram_wen), 0);
        check("rst_txdv",  32'(tx_dv), 0);
        check("rst_txb",   32'(tx_byte), 0);
        check("rst_waddr", 32'(ram_waddr), 0);
        check("rst_raddr", 32'(ram_raddr), 0);
        check("rst_wdata", 32'(ram_wdata), 0);
        preload = 1'b0;
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);

        // Write AA, BB at 0x010
        frame_buf[0] = 8'h02; frame_buf[1] = 8'h00; frame_buf[2] = 8'h10;
        frame_buf[3] = 8'hAA; frame_buf[4] = 8'hBB;
        do_frame(5, 1'b0); model_frame(5); compare_logs("write");

        // Read back 0x010..0x012
        frame_buf[0] = 8'h03; frame_buf[3] = 8'h5C; frame_buf[4] = 8'hE1;
        do_frame(5, 1'b0); model_frame(5); compare_logs("readback");

        // Wrap across 3FF -> 000, then read it back
        frame_buf[0] = 8'h02; frame_buf[1] = 8'h03; frame_buf[2] = 8'hFF;
        frame_buf[3] = 8'h11; frame_buf[4] = 8'h22;
        do_frame(5, 1'b0); model_frame(5); compare_logs("wrap_wr");
        frame_buf[0] = 8'h03; frame_buf[1] = 8'hFF; frame_buf[3] = 8'h00; frame_buf[4] = 8'h00;
        do_frame(5, 1'b0); model_frame(5); compare_logs("wrap_rd");

        // Abort right after the read address byte: nothing may be returned
        @(negedge clk); cs_n = 1'b0;
        @(negedge clk);
        send_byte(8'h03, sc); send_byte(8'h00, sc);
        @(negedge clk); rx_dv = 1'b1; rx_byte = 8'h10;
        @(negedge clk); rx_dv = 1'b0; cs_n = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_busy", 32'(busy), 0);
        compare_logs("abort");
        frame_buf[0] = 8'h02; frame_buf[1] = 8'h05; frame_buf[2] = 8'h00; frame_buf[3] = 8'hCC;
        do_frame(4, 1'b0); model_frame(4); compare_logs("after_abort");

        // Unknown opcode swallows the rest of the frame
        frame_buf[0] = 8'h7E; frame_buf[1] = 8'h02; frame_buf[2] = 8'h00;
        frame_buf[3] = 8'h00; frame_buf[4] = 8'h55;
        do_frame(5, 1'b1);
        check("ign_busy_hi", 32'(busy), 1);
        end_frame();
        check("ign_busy_lo", 32'(busy), 0);
        model_frame(5); compare_logs("ignore");

        // Async reset while a write strobe is active
        @(negedge clk); cs_n = 1'b0;
        @(negedge clk);
        send_byte(8'h02, sc); send_byte(8'h00, sc); send_byte(8'h20, sc);
        @(negedge clk); rx_dv = 1'b1; rx_byte = 8'h5A; sc = cyc;
        @(negedge clk); rx_dv = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_wen",   32'(ram_wen), 0);
        check("arst_busy",  32'(busy), 0);
        check("arst_waddr", 32'(ram_waddr), 0);
        check("arst_wdata", 32'(ram_wdata), 0);
        exp_wr.push_back('{10'h020, 8'h5A, sc + 1});
        cs_n = 1'b1; wcount = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        compare_logs("arst");
        frame_buf[0] = 8'h03; frame_buf[1] = 8'h00; frame_buf[2] = 8'h20; frame_buf[3] = 8'h00;
        do_frame(4, 1'b0); model_frame(4); compare_logs("arst_rd");

        // Status opcode (returns counts when enabled, ignored otherwise)
        frame_buf[0] = 8'h05; frame_buf[1] = 8'h00;
        do_frame(2, 1'b0); model_frame(2); compare_logs("status0");
        frame_buf[0] = 8'h02; frame_buf[1] = 8'h01; frame_buf[2] = 8'h80;
        frame_buf[3] = 8'h01; frame_buf[4] = 8'h02; frame_buf[5] = 8'h03;
        do_frame(6, 1'b0); model_frame(6); compare_logs("status_wr");
        frame_buf[0] = 8'h05; frame_buf[1] = 8'h00; frame_buf[2] = 8'h00;
        do_frame(3, 1'b0); model_frame(3); compare_logs("status3");

        // Randomised write / read-back / unknown-opcode frames
        for (int r = 0; r < 6; r++) begin
            ra = 10'($urandom_range(0, 1023));
            n  = $urandom_range(1, 4);
            frame_buf[0] = 8'h02;
            frame_buf[1] = {6'($urandom), ra[9:8]};
            frame_buf[2] = ra[7:0];
            for (int i = 0; i < n; i++) frame_buf[3 + i] = 8'($urandom);
            do_frame(3 + n, 1'b0); model_frame(3 + n); compare_logs("rnd_wr");
            frame_buf[0] = 8'h03;
            for (int i = 0; i < n; i++) frame_buf[3 + i] = 8'($urandom);
            do_frame(3 + n, 1'b0); model_frame(3 + n); compare_logs("rnd_rd");
            op = 8'($urandom);
            while (op == 8'h02 || op == 8'h03 || op == 8'h05) op = 8'($urandom);
            frame_buf[0] = op;
            for (int i = 1; i < 4; i++) frame_buf[i] = 8'($urandom);
            do_frame(4, 1'b0); model_frame(4); compare_logs("rnd_ign");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
Command sequencer between an SPI slave byte interface and the dual-port 1024x8 SPI RAM. It parses byte-stream commands (write, read, optional status), drives the RAM write and read ports, and auto-increments addresses. Read data is returned as TX bytes to the SPI slave. It is the only master of the RAM ports; both RAM clocks are tied to i_Clk at the top level.

Parameters:
ADDR_W, 10, RAM address width; depth is 2**ADDR_W
DATA_W, 8, byte width
CMD_WRITE, 8'h02, write opcode
CMD_READ, 8'h03, read opcode

Ports:
i_Clk  in  1  single clock for controller and both RAM ports
i_Rst  in  1  asynchronous, active-high reset
i_CS_n  in  1  SPI chip select, active low, synchronised upstream; high means end of transaction
i_RX_DV  in  1  one-cycle pulse, i_RX_Byte valid
i_RX_Byte  in  8  received byte
o_TX_DV  out  1  one-cycle pulse, o_TX_Byte loaded for the next SPI byte
o_TX_Byte  out  8  byte to shift out
o_RAM_wData  out  8  to RAM w_Data
o_RAM_wEnable  out  1  to RAM w_Enable
o_RAM_wAddress  out  10  to RAM w_Address
o_RAM_rAddress  out  10  to RAM r_Address
i_RAM_rData  in  8  from RAM r_Data (registered, 1-cycle read latency)
o_Busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async): state=IDLE; all outputs 0; internal address=0.
- FSM states: IDLE, ADDR_HI, ADDR_LO, WR_DATA, RD_DATA, IGNORE.
- IDLE: on i_RX_DV with i_CS_n=0, latch the opcode and go to ADDR_HI. Unknown opcode goes to IGNORE.
- ADDR_HI: on i_RX_DV, addr[9:8] = byte[1:0]; byte[7:2] is ignored. Go to ADDR_LO.
- ADDR_LO: on i_RX_DV, addr[7:0] = byte.
  - WRITE opcode: go to WR_DATA.
  - READ opcode: go to RD_DATA and issue the read of addr.
- WR_DATA: each i_RX_DV at cycle N drives o_RAM_wEnable=1 for exactly cycle N+1, with o_RAM_wAddress=addr and o_RAM_wData=byte. addr then increments.
- RD_DATA:
  - Read trigger is the ADDR_LO byte, then each subsequent i_RX_DV (a dummy byte; its value is ignored).
  - Trigger at cycle N: o_RAM_rAddress=addr at N+1; RAM data returns; o_TX_Byte=i_RAM_rData with o_TX_DV=1 at cycle N+3.
  - addr increments after each trigger except the ADDR_LO one. The first TX byte is mem[addr]; the next is mem[addr+1], and so on.
- Address increment wraps 1023 -> 0 in both modes.
- IGNORE: swallow bytes, no RAM access, no TX.
- i_CS_n=1 in any state: go to IDLE next cycle.
  - An i_RX_DV in the same cycle is discarded.
  - o_RAM_wEnable is forced 0.
  - A pending read pipeline is flushed, so no o_TX_DV follows.
- i_RX_DV pulses are guaranteed at least 4 cycles apart. Behaviour for closer spacing is undefined, but the FSM must not lock up.
- o_RAM_wEnable is never high in any state other than WR_DATA.
- o_TX_Byte holds its value between pulses.

Optional Feature:
SPI_RAM_CTRL_STATUS_EN
- Defined:
  - Opcode 8'h05 returns status with no address bytes: go directly to RD_STATUS.
  - o_TX_DV pulses 1 cycle after the opcode byte, with o_TX_Byte = 8-bit write counter.
  - The counter counts every o_RAM_wEnable cycle since reset and saturates at 8'hFF.
  - Further bytes repeat the current count with the same 1-cycle latency.
- Undefined: 8'h05 is an unknown opcode and goes to IGNORE. No counter logic is present.

Decomposition:
- Package spi_ram_pkg:
  - state enum;
  - opcode constants CMD_WRITE, CMD_READ, CMD_STATUS;
  - ADDR_W and DATA_W defaults.
- One natural sub-module: spi_ram_rd_pipe, the 3-stage read-valid shift register carrying trigger->TX valid, with flush on i_CS_n.
- The RAM is instantiated beside the controller at the top level, not inside it.

Test Plan:
- Write sequence: CS low; bytes 02, 00, 10, AA, BB; CS high -> wEnable pulses, writing mem[0x010]=AA and mem[0x011]=BB. No other wEnable.
- Read-back: 03, 00, 10, xx, xx -> o_TX_DV pulses give AA (3 cycles after the 3rd byte), then BB, then mem[0x012].
- Wrap: write 02, 03, FF, 11, 22 -> mem[0x3FF]=11, mem[0x000]=22. A read from 3FF returns 11, then 22.
- Abort: CS high in the cycle after the read address byte -> no o_TX_DV. Next transaction 02 05 00 CC writes mem[0x100]=CC.
- Unknown opcode 7E followed by 02, 00, 00, 55 in the same CS frame -> no wEnable. o_Busy stays high until CS high.
- Async reset asserted mid-WR_DATA -> outputs 0 immediately. With SPI_RAM_CTRL_STATUS_EN defined, 05 after reset returns 00; after 3 writes it returns 03.
